// File: rtl/gba_cart_host_if.sv
// gba_cart_host_if: request/response bundle between an internal requester and the cartridge host.
interface gba_cart_host_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_space;
  logic [24:0] req_addr;
  logic [7:0]  req_len;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_last;
  logic        busy;
  modport master (
    output req_valid, req_wr, req_space, req_addr, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, busy
  );
  modport slave (
    input  req_valid, req_wr, req_space, req_addr, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, busy
  );
endinterface

// File: rtl/gba_cart_host.sv
// gba_cart_host: console-side GBA cartridge initiator issuing CS1 ROM bursts and CS2 SRAM byte accesses.
module gba_cart_host #(
  parameter int T_SETUP   = 2,
  parameter int T_HOLD    = 2,
  parameter int T_STROBE  = 8,
  parameter int T_RECOVER = 4,
  parameter int T_IDLE    = 4
) (
  input  logic        clk,
  input  logic        rst,
  gba_cart_host_if.slave bus,
  output logic        o_cart_cs1_n,
  output logic        o_cart_cs2_n,
  output logic        o_cart_rd_n,
  output logic        o_cart_wr_n,
  inout  wire  [15:0] io_cart_adl,
  inout  wire  [7:0]  io_cart_adh
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_HOLD, S_STROBE, S_RECOVER, S_END} state_t;
  state_t      r_state, w_ns;
  logic [7:0]  r_cnt, r_beats, w_reload;
  logic        r_wr, r_space;
  logic [24:0] r_addr, w_addr;
  logic [15:0] r_wdata, w_wdata;
  logic        r_cs1_n, r_cs2_n, r_rd_n, r_wr_n;
  logic [15:0] r_adl, w_adl;
  logic [7:0]  r_adh, w_adh;
  logic        r_adl_oe, r_adh_oe, w_adl_oe, w_adh_oe;
  logic [15:0] r_rdata;
  logic        r_rsp_valid, r_rsp_last, r_ready, r_busy;
  logic        w_done, w_acc, w_rec_entry, w_wr, w_sp, w_cs_win, w_adr_ph, w_strb;
  assign w_done      = r_cnt == 8'd0;
  assign w_acc       = r_state == S_IDLE && bus.req_valid;
  assign w_rec_entry = r_state == S_STROBE && w_done;
  assign w_wr        = w_acc ? bus.req_wr : r_wr;
  assign w_sp        = w_acc ? bus.req_space : r_space;
  assign w_wdata     = w_acc ? bus.req_wdata : r_wdata;
  // SRAM address steps only when another beat follows, so a single write keeps its address on ADL
  assign w_addr      = w_acc ? bus.req_addr
                     : r_addr + {24'd0, r_space && w_rec_entry && r_beats != 8'd0};
  always_comb begin
    w_ns = r_state;
    case (r_state)
      S_IDLE:    w_ns = bus.req_valid ? S_ADDR : S_IDLE;
      S_ADDR:    w_ns = w_done ? S_HOLD : S_ADDR;
      S_HOLD:    w_ns = w_done ? S_STROBE : S_HOLD;
      S_STROBE:  w_ns = w_done ? S_RECOVER : S_STROBE;
      S_RECOVER: w_ns = !w_done ? S_RECOVER : (r_beats == 8'd0 ? S_END : S_STROBE);
      S_END:     w_ns = w_done ? S_IDLE : S_END;
      default:   w_ns = S_IDLE;
    endcase
  end
  assign w_reload = w_ns == S_ADDR    ? 8'(T_SETUP - 1)
                  : w_ns == S_HOLD    ? 8'(T_HOLD - 1)
                  : w_ns == S_STROBE  ? 8'(T_STROBE - 1)
                  : w_ns == S_RECOVER ? 8'(T_RECOVER - 1)
                  : w_ns == S_END     ? 8'(T_IDLE - 1) : 8'd0;
  // pin values are decoded from the next state so every pin comes straight from a flop
  assign w_cs_win = w_ns == S_HOLD || w_ns == S_STROBE || w_ns == S_RECOVER;
  assign w_adr_ph = w_ns == S_ADDR || w_ns == S_HOLD;
  assign w_strb   = w_ns == S_STROBE;
  assign w_adl_oe = w_sp ? w_ns != S_IDLE : (w_adr_ph || (w_wr && w_strb));
  assign w_adl    = w_sp ? w_addr[15:0] : (w_adr_ph ? w_addr[16:1] : w_wdata);
  assign w_adh_oe = w_sp ? (w_wr && w_strb) : w_adr_ph;
  assign w_adh    = w_sp ? w_wdata[7:0] : w_addr[24:17];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_beats     <= 8'd0;
      r_wr        <= 1'b0;
      r_space     <= 1'b0;
      r_addr      <= 25'd0;
      r_wdata     <= 16'd0;
      r_cs1_n     <= 1'b1;
      r_cs2_n     <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_adl       <= 16'd0;
      r_adh       <= 8'd0;
      r_adl_oe    <= 1'b0;
      r_adh_oe    <= 1'b0;
      r_rdata     <= 16'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_ns;
      r_cnt   <= w_ns != r_state ? w_reload : r_cnt - 8'd1;
      if (w_acc) begin
        r_wr    <= bus.req_wr;
        r_space <= bus.req_space;
        r_wdata <= bus.req_wdata;
        r_beats <= bus.req_wr ? 8'd0 : bus.req_len;
      end else if (r_state == S_RECOVER && w_done && r_beats != 8'd0) begin
        r_beats <= r_beats - 8'd1;
      end
      r_addr      <= w_addr;
      r_cs1_n     <= !(w_cs_win && !w_sp);
      r_cs2_n     <= !(w_cs_win && w_sp);
      r_rd_n      <= !(w_strb && !w_wr);
      r_wr_n      <= !(w_strb && w_wr);
      r_adl       <= w_adl;
      r_adh       <= w_adh;
      r_adl_oe    <= w_adl_oe;
      r_adh_oe    <= w_adh_oe;
      if (w_rec_entry) r_rdata <= r_space ? {8'h00, io_cart_adh} : io_cart_adl;
      r_rsp_valid <= w_rec_entry && !r_wr;
      r_rsp_last  <= w_rec_entry && !r_wr && r_beats == 8'd0;
      r_ready     <= w_ns == S_IDLE;
      r_busy      <= w_ns != S_IDLE;
    end
  end
  assign io_cart_adl   = r_adl_oe ? r_adl : 'z;
  assign io_cart_adh   = r_adh_oe ? r_adh : 'z;
  assign o_cart_cs1_n  = r_cs1_n;
  assign o_cart_cs2_n  = r_cs2_n;
  assign o_cart_rd_n   = r_rd_n;
  assign o_cart_wr_n   = r_wr_n;
  assign bus.req_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_last  = r_rsp_last;
endmodule
